// File: rtl/game_status.sv
// game_status: frame-level game-state monitor.
// Samples per-pixel obstacle flags during the visible scan, latches which
// obstacles were drawn in each complete frame, and runs a PLAY/WIN(/LOSE)
// state machine that drives the board LEDs.
// Optional feature: define GAME_TIMEOUT_EN to add a frame-count timeout that
// moves PLAY to LOSE after TIMEOUT_FRAMES frames without a win.
module game_status #(
    parameter int H_VIS          = 640,
    parameter int V_VIS          = 480,
    parameter int NUM_OBS        = 8,
    parameter int WIN_FRAMES     = 2,
    parameter int BLINK_FRAMES   = 30,
    parameter int TIMEOUT_FRAMES = 3600
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p_tick,
    input  logic               video_on,
    input  logic [10:0]        pixel_x,
    input  logic [10:0]        pixel_y,
    input  logic [NUM_OBS-1:0] obs_on,
    output logic [3:0]         obs_left,
    output logic               game_won,
    output logic               game_lost,
    output logic               frame_done,
    output logic [7:0]         leds
);

    localparam int EW = $clog2(WIN_FRAMES + 1);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {PLAY, WIN, LOSE} state_t;

    // Saturating increment of the empty-frame counter at WIN_FRAMES.
    function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] v);
        if (v >= EW'(WIN_FRAMES))
            return EW'(WIN_FRAMES);
        return v + 1'b1;
    endfunction

    // Number of obstacles set in a frame bitmap.
    function automatic logic [3:0] popcount(input logic [NUM_OBS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_OBS; i++)
            c = c + 4'(v[i]);
        return c;
    endfunction

    // Obstacle bitmap zero-padded onto the 8 LEDs.
    function automatic logic [7:0] pad_leds(input logic [NUM_OBS-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NUM_OBS-1:0] = v;
        return r;
    endfunction

    state_t             state_q, state_d;
    logic               synced_q;
    logic [NUM_OBS-1:0] seen_q;
    logic [NUM_OBS-1:0] alive_q;
    logic [EW-1:0]      empty_q;
    logic [BW-1:0]      blink_q, blink_d;
    logic [7:0]         leds_d;

    logic               sample, sof, eof_px, active, eof_act;
    logic [NUM_OBS-1:0] frame_bits;
    logic [EW-1:0]      empty_d;

    // A pixel counts only on a pixel-enable cycle inside the visible area.
    assign sample  = p_tick & video_on;
    assign sof     = sample && (pixel_x == 11'd0) && (pixel_y == 11'd0);
    assign eof_px  = sample && (pixel_x == 11'(H_VIS - 1)) && (pixel_y == 11'(V_VIS - 1));
    // The sof pixel itself already belongs to the first synced frame.
    assign active  = synced_q | sof;
    assign eof_act = active & eof_px;

    // The eof pixel is folded into the frame result.
    assign frame_bits = seen_q | obs_on;
    assign empty_d    = (frame_bits == '0) ? sat_inc(empty_q) : '0;

`ifdef GAME_TIMEOUT_EN
    localparam int FW = $clog2(TIMEOUT_FRAMES + 1);
    logic [FW-1:0] frame_q;
    logic [FW-1:0] frame_nxt;

    assign frame_nxt = frame_q + 1'b1;

    // Frame counter: advances on each synced eof while playing, frozen otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_q <= '0;
        else if (eof_act && state_q == PLAY)
            frame_q <= frame_nxt;
    end

    assign game_lost = (state_q == LOSE);
`else
    assign game_lost = 1'b0;
`endif

    // Frame sync, accumulator and per-frame results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            synced_q   <= 1'b0;
            seen_q     <= '0;
            alive_q    <= '1;
            obs_left   <= 4'(NUM_OBS);
            empty_q    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (sof)
                synced_q <= 1'b1;
            frame_done <= eof_act;
            if (eof_act) begin
                alive_q  <= frame_bits;
                obs_left <= popcount(frame_bits);
                seen_q   <= '0;
                empty_q  <= empty_d;
            end else if (active && sample) begin
                seen_q <= frame_bits;
            end
        end
    end

    // State, LED and blink-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PLAY;
            leds    <= pad_leds('1);
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            leds    <= leds_d;
            blink_q <= blink_d;
        end
    end

    // Next-state and LED pattern, evaluated once per synced eof.
    always_comb begin
        state_d = state_q;
        leds_d  = leds;
        blink_d = blink_q;
        if (eof_act) begin
            case (state_q)
                PLAY: begin
                    leds_d = pad_leds(frame_bits);
                    if (empty_d == EW'(WIN_FRAMES)) begin
                        state_d = WIN;
                        leds_d  = 8'hFF;
                        blink_d = '0;
                    end
`ifdef GAME_TIMEOUT_EN
                    else if (frame_nxt == FW'(TIMEOUT_FRAMES)) begin
                        state_d = LOSE;
                        leds_d  = 8'hAA;
                    end
`endif
                end
                WIN: begin
                    if (blink_q == BW'(BLINK_FRAMES - 1)) begin
                        blink_d = '0;
                        leds_d  = ~leds;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
                LOSE: begin
                    leds_d = 8'hAA;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    assign game_won = (state_q == WIN);

endmodule
